// File: rtl/symbol_uart_logger.sv
// Packs demodulated symbols LSB-first into bytes, queues them with packet markers, and streams them out as UART 8N1.
// Latency: completing strobe at N -> FIFO write N+1 -> pop N+2 -> start bit on uart_tx at N+3; frame is 10*CLK_DIV cycles.
// Backpressure: none upstream; writes to a full FIFO are dropped and latch fifo_overflow until reset.
module symbol_uart_logger #(
    parameter int          CLK_DIV = 139,
    parameter int          FIFO_AW = 4,
    parameter logic [7:0]  MARKER  = 8'h7E
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic update,
    input  logic value,
    input  logic packet_detected,
    output logic uart_tx,
    output logic busy,
    output logic fifo_overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic                update_q;
    logic                pkt_q;
    logic                sym_stb;
    logic                pkt_stb;
    logic [2:0]          bit_cnt;
    logic [7:0]          shift;
    logic                byte_vld;
    logic                marker_pend;

    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [CW-1:0]       count;
    logic                full;
    logic                empty;
    logic                wr_req;
    logic                wr_ok;
    logic [7:0]          wr_dat;

    tx_state_t           state;
    tx_state_t           state_nxt;
    logic [DW-1:0]       div_cnt;
    logic [2:0]          idx;
    logic [7:0]          tx_byte;
    logic                div_done;
    logic                pop;
    logic                tx_line;

    assign sym_stb = update & ~update_q;
    assign pkt_stb = packet_detected & ~pkt_q;

    // Registered copies of the strobe inputs for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_q <= 1'b0;
            pkt_q    <= 1'b0;
        end else begin
            update_q <= update;
            pkt_q    <= packet_detected;
        end
    end

    // Symbol packer: a packet strobe restarts the byte, and a coincident symbol becomes bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            if (!en) begin
                bit_cnt <= 3'd0;
            end else if (pkt_stb) begin
                if (sym_stb) begin
                    shift[0] <= value;
                    bit_cnt  <= 3'd1;
                end else begin
                    bit_cnt  <= 3'd0;
                end
            end else if (sym_stb) begin
                shift[bit_cnt] <= value;
                bit_cnt        <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_vld <= 1'b1;
                end
            end
        end
    end

    // Pending marker: set on a packet strobe, cleared once it gets the write port (data wins ties).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            marker_pend <= 1'b0;
        end else if (en && pkt_stb) begin
            marker_pend <= 1'b1;
        end else if (marker_pend && !byte_vld) begin
            marker_pend <= 1'b0;
        end
    end

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_req = byte_vld | marker_pend;
    assign wr_dat = byte_vld ? shift : MARKER;
    // A pop in the same cycle frees the slot, so a write to a full FIFO is still accepted then.
    assign wr_ok  = wr_req & (~full | pop);

    // FIFO storage and pointers; count tracks occupancy including simultaneous read/write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            if (wr_ok && !pop) begin
                count <= count + CW'(1);
            end else if (!wr_ok && pop) begin
                count <= count - CW'(1);
            end
            if (wr_req && !wr_ok) begin
                fifo_overflow <= 1'b1;
            end
        end
    end

    // FIFO memory array; no reset needed because reads are gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    assign div_done = (div_cnt == DW'(CLK_DIV - 1));

    // UART state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // UART next-state and line level; IDLE pops straight into START so frames are 1 idle cycle apart.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        tx_line   = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                tx_line = 1'b0;
                if (div_done) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                tx_line = tx_byte[idx];
                if (div_done && idx == 3'd7) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                tx_line = 1'b1;
                if (div_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit-period divider, data bit index and the byte latched at pop time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= 3'd0;
            tx_byte <= 8'd0;
        end else begin
            if (pop) begin
                tx_byte <= mem[rd_ptr];
            end
            if (state == IDLE) begin
                div_cnt <= '0;
                idx     <= 3'd0;
            end else if (div_done) begin
                div_cnt <= '0;
                if (state == DATA) begin
                    idx <= idx + 3'd1;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    assign uart_tx = tx_line;
    assign busy    = !empty || (state != IDLE);

endmodule
